// File: rtl/vgatiming.sv
// VGA 640x480@60 timing generator for SE-VGA: pixel/line counters plus registered
// sync, blank, SE-window and line/frame markers, all aligned to the counters they describe.
module vgatiming #(
  parameter int H_VIS      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VIS      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SE_H_START = 8,
  parameter int SE_V_START = 0
) (
  input  logic       pixClock,
  input  logic       nReset,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSEActive,
  output logic       vSEActive,
  output logic       nhSync,
  output logic       nvSync,
  output logic       vgaBlank,
  output logic       lineStart,
  output logic       frameStart
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_VIS_L  = 10'(H_VIS);
  localparam logic [9:0]  V_VIS_L  = 10'(V_VIS);
  localparam logic [9:0]  HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0]  HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0]  VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [10:0] SE_H_BEG = 11'(SE_H_START);
  localparam logic [10:0] SE_V_BEG = 11'(SE_V_START);

  logic [9:0]  r_h;
  logic [9:0]  r_v;
  logic        r_hse;
  logic        r_vse;
  logic        r_nhs;
  logic        r_nvs;
  logic        r_blank;
  logic        r_ls;
  logic        r_fs;

  logic        w_h_wrap;
  logic [9:0]  w_h_next;
  logic [9:0]  w_v_next;
  logic [10:0] w_h_off;
  logic [10:0] w_v_off;
  logic        w_hse;
  logic        w_vse;
  logic        w_nhs;
  logic        w_nvs;
  logic        w_blank;
  logic        w_ls;
  logic        w_fs;

  // Next-state counters fold in reset so the flags below always describe the
  // exact counter values loaded on the same edge.
  always_comb begin
    w_h_wrap = (r_h == H_LAST);
    w_h_next = w_h_wrap ? 10'd0 : r_h + 10'd1;
    w_v_next = r_v;
    if (w_h_wrap) begin
      w_v_next = (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
    end
    if (!nReset) begin
      w_h_next = 10'd0;
      w_v_next = 10'd0;
    end
  end

  // Window tests via an 11-bit offset: the borrow bit means "before the window".
  always_comb begin
    w_h_off = {1'b0, w_h_next} - SE_H_BEG;
    w_v_off = {1'b0, w_v_next} - SE_V_BEG;
    w_hse   = !w_h_off[10] && (w_h_off[9:0] < 10'd512);
    w_vse   = !w_v_off[10] && (w_v_off[9:0] < 10'd342);
    w_nhs   = !((w_h_next >= HS_BEG) && (w_h_next < HS_END));
    w_nvs   = !((w_v_next >= VS_BEG) && (w_v_next < VS_END));
    w_blank = (w_h_next >= H_VIS_L) || (w_v_next >= V_VIS_L);
    w_ls    = (w_h_next == 10'd0);
    w_fs    = (w_h_next == 10'd0) && (w_v_next == 10'd0);
  end

  always_ff @(posedge pixClock) begin
    if (!nReset) begin
      r_h <= 10'd0;
      r_v <= 10'd0;
    end else begin
      r_h <= w_h_next;
      r_v <= w_v_next;
    end
    r_hse   <= w_hse;
    r_vse   <= w_vse;
    r_nhs   <= w_nhs;
    r_nvs   <= w_nvs;
    r_blank <= w_blank;
    r_ls    <= w_ls;
    r_fs    <= w_fs;
  end

  assign hCount     = r_h;
  assign vCount     = r_v;
  assign hSEActive  = r_hse;
  assign vSEActive  = r_vse;
  assign nhSync     = r_nhs;
  assign nvSync     = r_nvs;
  assign vgaBlank   = r_blank;
  assign lineStart  = r_ls;
  assign frameStart = r_fs;

endmodule

// File: tb/tb_vgatiming.sv
// Directed bench for vgatiming: a full-size instance for reset and line decode, and a
// short-line instance (24 clocks/line) so whole frames fit in a short run.
module tb_vgatiming;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  always #20 clk = ~clk;

  logic [9:0] d_h, d_v, f_h, f_v;
  logic d_hse, d_vse, d_nh, d_nv, d_blank, d_ls, d_fs;
  logic f_hse, f_vse, f_nh, f_nv, f_blank, f_ls, f_fs;

  vgatiming u_dut (
    .pixClock(clk), .nReset(nReset), .hCount(d_h), .vCount(d_v),
    .hSEActive(d_hse), .vSEActive(d_vse), .nhSync(d_nh), .nvSync(d_nv),
    .vgaBlank(d_blank), .lineStart(d_ls), .frameStart(d_fs)
  );

  vgatiming #(.H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(2)) u_fast (
    .pixClock(clk), .nReset(nReset), .hCount(f_h), .vCount(f_v),
    .hSEActive(f_hse), .vSEActive(f_vse), .nhSync(f_nh), .nvSync(f_nv),
    .vgaBlank(f_blank), .lineStart(f_ls), .frameStart(f_fs)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int eh = 0, ev = 0, fh = 0, fv = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference decode written directly from the timing table (800x525 and 24x525).
  task automatic chk_all();
    chk("d_h", d_h, eh);
    chk("d_v", d_v, ev);
    chk("d_hse", d_hse, (eh >= 8 && eh < 520));
    chk("d_vse", d_vse, (ev < 342));
    chk("d_nh", d_nh, !(eh >= 656 && eh < 752));
    chk("d_nv", d_nv, !(ev >= 490 && ev < 492));
    chk("d_blank", d_blank, (eh >= 640 || ev >= 480));
    chk("d_ls", d_ls, (eh == 0));
    chk("d_fs", d_fs, (eh == 0 && ev == 0));
    chk("f_h", f_h, fh);
    chk("f_v", f_v, fv);
    chk("f_hse", f_hse, (fh >= 8));
    chk("f_vse", f_vse, (fv < 342));
    chk("f_nh", f_nh, !(fh >= 18 && fh < 22));
    chk("f_nv", f_nv, !(fv >= 490 && fv < 492));
    chk("f_blank", f_blank, (fh >= 16 || fv >= 480));
    chk("f_ls", f_ls, (fh == 0));
    chk("f_fs", f_fs, (fh == 0 && fv == 0));
  endtask

  task automatic tick(input logic rst_n);
    nReset = rst_n;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      eh = 0; ev = 0; fh = 0; fv = 0;
    end else begin
      eh++;
      if (eh == 800) begin eh = 0; ev = (ev == 524) ? 0 : ev + 1; end
      fh++;
      if (fh == 24) begin fh = 0; fv = (fv == 524) ? 0 : fv + 1; end
    end
    chk_all();
  endtask

  initial begin
    int hse_cnt, hse_first, hse_last, nh_cnt, nh_first, nh_last, blank_first;
    int period, vse_lines, nv_cnt, nv_first, nv_last, ls_cnt, max_h, max_v;
    int prev_h, prev_v;
    bit found;

    tick(1'b0);
    tick(1'b0);
    repeat (37) tick(1'b1);
    chk("count_37", d_h, 37);

    // Reset hold from an arbitrary count.
    repeat (5) begin
      tick(1'b0);
      chk("rst_h", d_h, 0);
      chk("rst_v", d_v, 0);
      chk("rst_vse", d_vse, 1);
      chk("rst_hse", d_hse, 0);
      chk("rst_nh", d_nh, 1);
      chk("rst_nv", d_nv, 1);
      chk("rst_blank", d_blank, 0);
      chk("rst_ls", d_ls, 1);
      chk("rst_fs", d_fs, 1);
    end
    tick(1'b1);
    chk("rel_h", d_h, 1);
    chk("rel_ls", d_ls, 0);
    chk("rel_fs", d_fs, 0);

    // One full line of horizontal decode on the full-size instance.
    hse_cnt = 0; hse_first = -1; hse_last = -1;
    nh_cnt = 0; nh_first = -1; nh_last = -1; blank_first = -1;
    repeat (798) begin
      tick(1'b1);
      if (d_hse) begin
        hse_cnt++;
        if (hse_first < 0) hse_first = int'(d_h);
        hse_last = int'(d_h);
      end
      if (!d_nh) begin
        nh_cnt++;
        if (nh_first < 0) nh_first = int'(d_h);
        nh_last = int'(d_h);
      end
      if (d_blank && blank_first < 0) blank_first = int'(d_h);
    end
    chk("hse_first", hse_first, 8);
    chk("hse_last", hse_last, 519);
    chk("hse_count", hse_cnt, 512);
    chk("nh_first", nh_first, 656);
    chk("nh_last", nh_last, 751);
    chk("nh_count", nh_cnt, 96);
    chk("blank_rise", blank_first, 640);
    chk("pre_wrap_h", d_h, 799);
    chk("pre_wrap_v", d_v, 0);
    tick(1'b1);
    chk("wrap_h", d_h, 0);
    chk("wrap_v", d_v, 1);
    chk("wrap_ls", d_ls, 1);
    chk("wrap_fs", d_fs, 0);

    // Align to the short-line instance's next frame start.
    found = 0;
    for (int i = 0; i < 13000 && !found; i++) begin
      tick(1'b1);
      if (f_fs) found = 1;
    end
    chk("fast_fs_found", found, 1);

    // One full frame of vertical decode.
    period = 0; vse_lines = 0; nv_cnt = 0; nv_first = -1; nv_last = -1;
    ls_cnt = 1; max_h = 0; max_v = 0; found = 0;
    prev_h = int'(f_h); prev_v = int'(f_v);
    if (f_vse) vse_lines++;
    for (int i = 0; i < 13000 && !found; i++) begin
      prev_h = int'(f_h);
      prev_v = int'(f_v);
      tick(1'b1);
      period++;
      if (f_fs) begin
        found = 1;
        chk("fwrap_prev_h", prev_h, 23);
        chk("fwrap_prev_v", prev_v, 524);
        chk("fwrap_ls", f_ls, 1);
        chk("fwrap_v", f_v, 0);
      end else begin
        if (f_ls) ls_cnt++;
        if (f_ls && f_vse) vse_lines++;
        if (!f_nv) begin
          nv_cnt++;
          if (nv_first < 0) nv_first = int'(f_v);
          nv_last = int'(f_v);
        end
        if (int'(f_h) > max_h) max_h = int'(f_h);
        if (int'(f_v) > max_v) max_v = int'(f_v);
      end
    end
    chk("frame_period", period, 12600);
    chk("vse_lines", vse_lines, 342);
    chk("nv_count", nv_cnt, 48);
    chk("nv_first", nv_first, 490);
    chk("nv_last", nv_last, 491);
    chk("lines_per_frame", ls_cnt, 525);
    chk("max_h", max_h, 23);
    chk("max_v", max_v, 524);

    // Mid-frame reset at (10,200) on the short-line instance.
    found = 0;
    for (int i = 0; i < 13000 && !found; i++) begin
      tick(1'b1);
      if (f_h == 10'd10 && f_v == 10'd200) found = 1;
    end
    chk("mid_pos_found", found, 1);
    tick(1'b0);
    chk("mid_h", f_h, 0);
    chk("mid_v", f_v, 0);
    chk("mid_ls", f_ls, 1);
    chk("mid_fs", f_fs, 1);
    chk("mid_vse", f_vse, 1);
    chk("mid_hse", f_hse, 0);
    chk("mid_nh", f_nh, 1);
    period = 0; found = 0;
    for (int i = 0; i < 13000 && !found; i++) begin
      tick(1'b1);
      period++;
      if (f_fs) found = 1;
    end
    chk("mid_next_fs", period, 12600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vgatiming.md
# vgatiming

Free-running VGA 640x480@60 timing generator for SE-VGA, clocked by the 25.175 MHz pixel clock. It produces the horizontal and vertical pixel counters and the SE-window active flags consumed by the video output stage (vgaout). It also produces the VGA sync, blanking and frame/line markers. Window placement matches vgaout's fetch pipeline, so no other stage needs to offset hCount or vCount.

## Interface
Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SE_H_START, 8, first hCount of the SE window (width fixed at 512)
- SE_V_START, 0, first vCount of the SE window (height fixed at 342)

Ports:
- pixClock  in  1  pixel clock; all state changes on its rising edge
- nReset  in  1  reset; one clock, synchronous, active-low
- hCount  out  10  horizontal position, 0..H_TOTAL-1
- vCount  out  10  vertical position, 0..V_TOTAL-1
- hSEActive  out  1  high while hCount is inside the SE horizontal window
- vSEActive  out  1  high while vCount is inside the SE vertical window
- nhSync  out  1  horizontal sync, active low
- nvSync  out  1  vertical sync, active low
- vgaBlank  out  1  high outside the 640x480 visible area
- lineStart  out  1  one-cycle pulse while hCount==0
- frameStart  out  1  one-cycle pulse while hCount==0 and vCount==0

## Operation
- H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525. All comparisons use 10-bit unsigned values.
- hCount increments every clock. At H_TOTAL-1 it wraps to 0.
- vCount increments only on the cycle hCount wraps. When vCount is at V_TOTAL-1 on a wrap, it goes to 0.
- hSEActive = (SE_H_START <= hCount < SE_H_START+512). Default window is 8..519.
  - vgaout fetches byte n at hCount = 8n+7 and shows it during 8n+8..8n+15.
- vSEActive = (SE_V_START <= vCount < SE_V_START+342). Default window is 0..341, matching vramAddr[14:6] = vCount[8:0].
- nhSync = 0 for H_VIS+H_FP <= hCount < H_VIS+H_FP+H_SYNC (656..751). It is 1 otherwise.
- nvSync = 0 for V_VIS+V_FP <= vCount < V_VIS+V_FP+V_SYNC (490..491). It is 1 otherwise.
- vgaBlank = (hCount >= H_VIS) or (vCount >= V_VIS).
- Flag registration:
  - All flags are registers, decoded from the next-state counter values.
  - Every flag therefore describes the hCount/vCount value presented in the same cycle. There is no skew between counters and flags.
  - No combinational path exists from the counters to any output.
- Sync polarity is fixed negative for both syncs (640x480 mode).
- There is no enable or pause. The block is free-running whenever nReset is high.

## Timing
- Reset: nReset sampled low at a rising edge loads hCount=0 and vCount=0. Every flag takes its decode of (0,0):
  - hSEActive=0, vSEActive=1
  - nhSync=1, nvSync=1
  - vgaBlank=0
  - lineStart=1, frameStart=1
- Reset mid-line or mid-frame has the same effect. Counting resumes from (0,0) on the first edge with nReset high.
- Holding nReset low for N cycles holds the reset values for all N cycles.
- First edge after release: hCount=1, lineStart=0, frameStart=0.
- Line wrap at hCount 799→0:
  - vCount updates on the same edge.
  - lineStart is high for exactly that one cycle.
  - vSEActive and nvSync change on that edge only.
- Frame wrap at (799,524)→(0,0): both counters clear on one edge, and frameStart and lineStart assert together.
- Periods: 800 clocks per line; 420000 clocks per frame.
  - nhSync low 96 clocks per line.
  - nvSync low 1600 clocks per frame.
  - hSEActive high 512 clocks per line.
  - vSEActive high 342 lines per frame.

## Test plan
- Reset hold: hold nReset low 5 cycles at arbitrary counts -> every cycle shows hCount=0, vCount=0, vSEActive=1, hSEActive=0, nhSync=1, nvSync=1, lineStart=1, frameStart=1; the next cycle shows hCount=1.
- Horizontal decode: run one line from reset ->
  - hSEActive first high at hCount=8, last high at 519.
  - nhSync low exactly for hCount 656..751.
  - vgaBlank rises at 640.
  - hCount goes 799→0 with vCount 0→1.
- Vertical decode: run one full frame ->
  - vSEActive high for vCount 0..341.
  - nvSync low for vCount 490..491, i.e. 1600 clocks.
  - vgaBlank high for all of vCount 480..524.
  - frameStart pulses once per 420000 clocks.
- Wrap: observe (799,524) -> the next cycle is (0,0) with frameStart=1 and lineStart=1; vCount never reaches 525 and hCount never reaches 800.
- Mid-frame reset: assert nReset for 1 cycle at (300,200) -> the next cycle is (0,0) with the reset flag values, then normal counting; the following frameStart arrives 420000 clocks later.
- Alignment with vgaout: pair with vgaout and a VRAM model holding byte n = n -> nvramOE pulses at hCount 8n+7 for n=0..63 on each SE line, with vramAddr[5:0]=n and vramAddr[14:6]=vCount; no pulses occur for vCount >= 342.
